// File: rtl/ir_queue.sv
// Instruction register with a DEPTH-entry prefetch queue.
// Head word is split into opcode (MSBs) and operand (LSBs) fields.
module ir_queue #(
  parameter int OP_W  = 4,
  parameter int ARG_W = 4,
  parameter int DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         clear,
  input  logic [OP_W+ARG_W-1:0]        in_data,
  input  logic                         load,
  output logic                         in_ready,
  input  logic                         advance,
  input  logic                         flush,
  output logic [OP_W-1:0]              ir_op,
  output logic [ARG_W-1:0]             ir_arg,
  output logic                         ir_valid,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         ovf
);

  localparam int W  = OP_W + ARG_W;
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic [CW-1:0] count_q;
  logic          ovf_q;
  logic          push;
  logic          pop;
  logic [W-1:0]  head;

  assign in_ready = (count_q != CW'(DEPTH));
  assign ir_valid = (count_q != '0);
  assign push     = load && in_ready;
  assign pop      = advance && ir_valid;
  assign count    = count_q;
  assign ovf      = ovf_q;

  assign head   = ir_valid ? mem[rd_ptr] : '0;
  assign ir_op  = head[W-1:ARG_W];
  assign ir_arg = head[ARG_W-1:0];

  // A flush restarts the buffer at slot 0, so a concurrent push lands there.
  always_ff @(posedge clk) begin
    if (!clear && push) begin
      mem[flush ? '0 : wr_ptr] <= in_data;
    end
  end

  always_ff @(posedge clk) begin
    if (clear) begin
      rd_ptr  <= '0;
      wr_ptr  <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      if (load && !in_ready) begin
        ovf_q <= 1'b1;
      end
      if (flush) begin
        rd_ptr <= '0;
        if (push) begin
          wr_ptr  <= PW'(1);
          count_q <= CW'(1);
        end else begin
          wr_ptr  <= '0;
          count_q <= '0;
        end
      end else begin
        if (push) begin
          wr_ptr <= wr_ptr + PW'(1);
        end
        if (pop) begin
          rd_ptr <= rd_ptr + PW'(1);
        end
        case ({push, pop})
          2'b10:   count_q <= count_q + CW'(1);
          2'b01:   count_q <= count_q - CW'(1);
          default: count_q <= count_q;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ir_queue.sv
// Directed self-checking bench for ir_queue with default parameters.
module tb_ir_queue;

  logic       clk = 1'b0;
  logic       clear;
  logic [7:0] in_data;
  logic       load;
  logic       in_ready;
  logic       advance;
  logic       flush;
  logic [3:0] ir_op;
  logic [3:0] ir_arg;
  logic       ir_valid;
  logic [2:0] count;
  logic       ovf;

  int errs   = 0;
  int checks = 0;

  ir_queue #(.OP_W(4), .ARG_W(4), .DEPTH(4)) dut (
    .clk      (clk),
    .clear    (clear),
    .in_data  (in_data),
    .load     (load),
    .in_ready (in_ready),
    .advance  (advance),
    .flush    (flush),
    .ir_op    (ir_op),
    .ir_arg   (ir_arg),
    .ir_valid (ir_valid),
    .count    (count),
    .ovf      (ovf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Inputs change 1 time unit after the edge, outputs are sampled there too.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    clear = 0; load = 0; advance = 0; flush = 0; in_data = 8'h00;
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, ".in_ready"}, 16'(in_ready), 16'd1);
    chk({tag, ".ir_valid"}, 16'(ir_valid), 16'd0);
    chk({tag, ".head"}, {8'h00, ir_op, ir_arg}, 16'h0000);
    chk({tag, ".count"}, 16'(count), 16'd0);
    chk({tag, ".ovf"}, 16'(ovf), 16'd0);
  endtask

  task automatic push(input logic [7:0] d);
    idle(); load = 1; in_data = d; step(); idle();
  endtask

  initial begin
    logic [7:0] exp_head;
    idle();
    clear = 1; step(); idle();
    chk_reset("reset");

    // single push and retire
    push(8'hA5);
    chk("t1.valid", 16'(ir_valid), 16'd1);
    chk("t1.op", 16'(ir_op), 16'h000A);
    chk("t1.arg", 16'(ir_arg), 16'h0005);
    chk("t1.count", 16'(count), 16'd1);
    advance = 1; step(); idle();
    chk("t1.pop_valid", 16'(ir_valid), 16'd0);
    chk("t1.pop_head", {8'h00, ir_op, ir_arg}, 16'h0000);
    chk("t1.pop_count", 16'(count), 16'd0);

    // fill, overflow, drain
    push(8'h11); push(8'h22); push(8'h33); push(8'h44);
    chk("t2.in_ready", 16'(in_ready), 16'd0);
    chk("t2.count", 16'(count), 16'd4);
    chk("t2.ovf_pre", 16'(ovf), 16'd0);
    push(8'h55);
    chk("t2.ovf", 16'(ovf), 16'd1);
    chk("t2.count_full", 16'(count), 16'd4);
    for (int i = 0; i < 4; i++) begin
      exp_head = 8'h11 * 8'(i + 1);
      chk($sformatf("t2.head%0d", i), {8'h00, ir_op, ir_arg}, {8'h00, exp_head});
      advance = 1; step(); idle();
    end
    chk("t2.drained", 16'(count), 16'd0);
    chk("t2.ovf_sticky", 16'(ovf), 16'd1);

    // steady-state push+pop across pointer wrap
    clear = 1; step(); idle();
    push(8'h50); push(8'h51);
    for (int k = 0; k < 6; k++) begin
      load = 1; advance = 1; in_data = 8'h60 + 8'(k); step(); idle();
      exp_head = (k == 0) ? 8'h51 : 8'h60 + 8'(k - 1);
      chk($sformatf("t3.count%0d", k), 16'(count), 16'd2);
      chk($sformatf("t3.head%0d", k), {8'h00, ir_op, ir_arg}, {8'h00, exp_head});
    end
    chk("t3.ovf", 16'(ovf), 16'd0);

    // flush with and without load
    push(8'h70);
    chk("t4.count3", 16'(count), 16'd3);
    flush = 1; load = 1; in_data = 8'h9C; step(); idle();
    chk("t4.count", 16'(count), 16'd1);
    chk("t4.op", 16'(ir_op), 16'h0009);
    chk("t4.arg", 16'(ir_arg), 16'h000C);
    flush = 1; step(); idle();
    chk("t4.count0", 16'(count), 16'd0);
    chk("t4.valid0", 16'(ir_valid), 16'd0);
    chk("t4.ovf", 16'(ovf), 16'd0);

    // flush keeps ovf, then clear overrides load/advance on a full queue
    push(8'h01); push(8'h02); push(8'h03); push(8'h04); push(8'h05);
    chk("t5.ovf_set", 16'(ovf), 16'd1);
    flush = 1; step(); idle();
    chk("t5.flush_ovf", 16'(ovf), 16'd1);
    chk("t5.flush_ready", 16'(in_ready), 16'd1);
    push(8'h01); push(8'h02); push(8'h03); push(8'h04);
    chk("t5.full", 16'(count), 16'd4);
    clear = 1; load = 1; advance = 1; in_data = 8'hFF; step(); idle();
    chk_reset("t5.clear");

    // advance on empty with load
    load = 1; advance = 1; in_data = 8'h3E; step(); idle();
    chk("t6.count", 16'(count), 16'd1);
    chk("t6.head", {8'h00, ir_op, ir_arg}, 16'h003E);
    chk("t6.valid", 16'(ir_valid), 16'd1);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule

// File: doc/ir_queue.md
# ir_queue

Parametrised instruction register with a DEPTH-entry prefetch queue. It sits between instruction fetch and the control unit. It accepts fetched instruction words with a load/ready handshake and presents the oldest word split into an opcode field (to the control unit) and an operand field (to the PC/address path). The control unit retires the word with `advance`. Over the single-word instruction register it adds configurable field widths, prefetch buffering, flush for branches, occupancy reporting and sticky overflow detection.

## Interface

Parameters:
- `OP_W`, default 4: opcode field width, taken from the MSBs of the word.
- `ARG_W`, default 4: operand field width, taken from the LSBs of the word.
- `DEPTH`, default 4: queue entries. Must be a power of 2 and at least 2.

Ports:
- `clk`  input  1  rising-edge clock. This is the only clock.
- `clear`  input  1  synchronous, active-high reset.
- `in_data`  input  OP_W+ARG_W  fetched instruction word.
- `load`  input  1  push request.
- `in_ready`  output  1  queue can accept a push this cycle.
- `advance`  input  1  control unit retires the current instruction.
- `flush`  input  1  discard all queued words (taken branch or jump).
- `ir_op`  output  OP_W  opcode of the head entry. Equals `in_data[OP_W+ARG_W-1:ARG_W]` of the stored word.
- `ir_arg`  output  ARG_W  operand of the head entry. Equals `in_data[ARG_W-1:0]` of the stored word.
- `ir_valid`  output  1  head entry present.
- `count`  output  $clog2(DEPTH+1)  number of occupied entries, 0..DEPTH.
- `ovf`  output  1  sticky flag: a push was attempted while full.

## Operation

Storage:
- DEPTH-word circular buffer with a read pointer, a write pointer and an occupancy counter.
- Pointers are $clog2(DEPTH) bits wide and wrap modulo DEPTH.

Handshake signals:
- `in_ready = (count != DEPTH)`. It is a function of registered state only and does not depend on `advance` in the same cycle.
- push = `load && in_ready`.
- pop = `advance && ir_valid`. An `advance` while empty is ignored.

Outputs:
- `ir_valid = (count != 0)`.
- `ir_op` and `ir_arg` are driven from the head storage entry when `ir_valid = 1`, and are forced to 0 when `ir_valid = 0`.
- No combinational path exists from `in_data`, `load` or `advance` to any output.

Priority per clock edge, highest first:
1. `clear`: empties the queue (pointers 0, `count` 0) and clears `ovf`. All other inputs are ignored that cycle.
2. `flush`: discards all entries. If `load` is also 1 that cycle, `in_data` is written as the only entry (`count` becomes 1). Otherwise `count` becomes 0. `advance` is ignored. For this rule `in_ready` is evaluated before the flush, so a push is accepted only if `in_ready` was 1.
3. Normal operation:
   - push only: `count` +1.
   - pop only: `count` −1.
   - push and pop together: `count` unchanged, both pointers advance. This is legal at any occupancy from 1 to DEPTH−1.
   - When `count = DEPTH`, push is refused even if a pop occurs in the same cycle.

Overflow:
- `load && !in_ready` sets `ovf` on the next edge.
- `ovf` stays set until `clear`. `flush` does not clear it.
- The refused word is dropped, and the queue contents are unchanged by the refused push.

## Timing

- Reset state of every output: `in_ready = 1`, `ir_valid = 0`, `ir_op = 0`, `ir_arg = 0`, `count = 0`, `ovf = 0`.
- Push-to-visible latency is 1 cycle: a word pushed at edge N appears on `ir_op`/`ir_arg` with `ir_valid = 1` after edge N, if the queue was empty.
- After a pop at edge N, the next entry (or zeros if the queue is now empty) is presented after edge N.
- After a flush at edge N, `in_ready = 1` after edge N.
- `count`, `in_ready` and `ovf` update on the same edge as the event that changes them.
- Pointer wrap from DEPTH−1 to 0 causes no bubble.
- `clear` asserted mid-stream takes effect at the next edge regardless of `load`, `advance` or `flush`.

## Test plan

- Reset, then push 0xA5. Required: one cycle later `ir_valid = 1`, `ir_op = 0xA`, `ir_arg = 0x5`, `count = 1`. Then `advance`. Required: `ir_valid = 0`, outputs 0, `count = 0`.
- Push 0x11, 0x22, 0x33, 0x44 back to back (DEPTH = 4). Required: `in_ready = 0`, `count = 4`. Then `load` 0x55 while full. Required: `ovf = 1`, 0x55 dropped. Then pop 4 times. Required: heads are 0x11, 0x22, 0x33, 0x44 in order.
- Hold `count = 2`, then assert `load` and `advance` together for 6 cycles with words 0x60–0x65. Required: `count` stays 2, heads emerge in order across the pointer wrap, no `ovf`.
- Fill to 3 entries, then assert `flush` together with `load` 0x9C. Required next cycle: `count = 1`, `ir_op = 0x9`, `ir_arg = 0xC`. Repeat `flush` without `load`. Required: `count = 0`, `ovf` unchanged.
- Queue full with `ovf = 1`, then assert `clear` together with `load` and `advance`. Required next cycle: all outputs at reset values, `in_ready = 1`.
- `advance` on an empty queue, together with `load` 0x3E. Required: no underflow, `count = 1`, head = 0x3E.
